uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//   8N1 UART transmitter; the transmit-side counterpart of uart_receiver.
//   Accepts one byte per handshake and serialises it LSB-first onto UART_TX
//   with a start bit, 8 data bits and one stop bit. Sits between user logic
//   (e.g. echo of received bytes, button/LED status) and the board's TX pin.
// PARAMETERS
//   CLK_HZ        12_000_000  input clock frequency in Hz
//   BAUD          9600        line bit rate
//   CLKS_PER_BIT  CLK_HZ/BAUD derived localparam; integer division; must be >= 2
// PORTS
//   CLK       in   1  system clock; all logic on posedge
//   RST_N     in   1  asynchronous, active-low reset
//   tx_start  in   1  request; sampled only while tx_busy==0
//   tx_byte   in   8  data; captured in the same cycle as an accepted tx_start
//   tx_busy   out  1  high from the cycle after acceptance until the frame ends
//   tx_done   out  1  one-cycle pulse on the cycle the FSM returns to IDLE
//   UART_TX   out  1  serial line; idle high
// BEHAVIOUR
//   - Reset (RST_N=0, async): UART_TX=1, tx_busy=0, tx_done=0, FSM=IDLE.
//     Bit counter, baud counter and shift register cleared. Mid-frame reset
//     aborts the frame immediately; the line returns high with no glitch low.
//   - UART_TX is driven from a register, never combinationally.
//   - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//     IDLE  : UART_TX=1. If tx_start=1, latch tx_byte, go to START.
//     START : UART_TX=0 for CLKS_PER_BIT cycles.
//     DATA  : UART_TX=shift[0]; shift right every CLKS_PER_BIT cycles.
//             After bit index 7 (3-bit counter, no wrap past 7), leave DATA.
//     STOP  : UART_TX=1 for CLKS_PER_BIT cycles, then IDLE with tx_done=1.
//   - Latency: tx_start high in cycle N (IDLE) -> UART_TX=0 and tx_busy=1
//     from cycle N+1. The frame occupies 10*CLKS_PER_BIT cycles (11* with parity).
//   - Baud counter counts 0..CLKS_PER_BIT-1 and reloads at 0 on each bit
//     boundary; it is held at 0 in IDLE.
//   - tx_start while tx_busy=1 is ignored; tx_byte changes mid-frame have no effect.
//   - Back-to-back: tx_start held high -> the next start bit begins 1 cycle
//     after tx_done (one IDLE cycle between frames; the stop bit is never shortened).
//   - tx_done and tx_busy are never both high; tx_done falls in cycle N+1 even
//     when a new request is accepted in the done cycle.
// CONFIGURATION
//   UART_TX_PARITY_EN defined: a PARITY state follows DATA and drives
//     ^tx_byte (even parity) for CLKS_PER_BIT cycles; frame = 11 bit times.
//   Undefined: no PARITY state, DATA goes straight to STOP; pure 8N1.
// TESTING  (sim params CLK_HZ=16, BAUD=1 -> CLKS_PER_BIT=16)
//   - Reset: hold RST_N=0 -> UART_TX=1, tx_busy=0, tx_done=0. Release RST_N and
//     drive no tx_start -> UART_TX stays 1.
//   - Send 0xA5: pulse tx_start 1 cycle -> the line reads 0,1,0,1,0,0,1,0,1,1,
//     each bit 16 cycles; tx_done pulses once, 160 cycles after the start-bit edge.
//   - Busy ignore: 0x3C in flight, tx_start with 0xFF at cycle 40 -> only
//     0x3C is sent; no second frame.
//   - Back-to-back: hold tx_start=1 with 0x00 then 0xFF -> two frames; exactly
//     one idle-high cycle between the stop bit and the next start bit.
//   - Mid-frame reset: assert RST_N=0 during bit 3 of 0x00 -> UART_TX=1 at
//     once, tx_busy=0; a later 0x55 transmits correctly.
//   - UART_TX_PARITY_EN: 0xA5 -> parity bit 0; 0x01 -> parity bit 1; frame=176 cycles.

Source files
------------

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : uart_transmitter
// Description : 8N1 UART transmitter. It accepts one byte per tx_start
//               handshake and sends it LSB-first with start and stop bits.
//               Define UART_TX_PARITY_EN to add an even-parity bit (8E1).
// Revision    : 1.0  initial release
// ============================================================================
module uart_transmitter #(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       UART_TX
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] C_BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q,  baud_d;
    logic [2:0]       bit_q,   bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q,    tx_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
`ifdef UART_TX_PARITY_EN
    logic             par_q,   par_d;
`endif

    logic baud_end;
    assign baud_end = (baud_q == C_BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    state_d = S_START;
                    shift_d = tx_byte;
                    bit_d   = 3'd0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^tx_byte;
`endif
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        // The line register is loaded with the next bit as the shift happens.
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bit_d   = 3'd0;
                    shift_d = 8'h00;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign UART_TX = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// Self-checking bench for uart_transmitter at CLK_HZ=16, BAUD=1 (16 clocks per bit).
module tb_uart_transmitter;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       CLK      = 1'b0;
    logic       RST_N    = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_byte  = 8'h00;
    logic       tx_busy;
    logic       tx_done;
    logic       UART_TX;

    int vectors     = 0;
    int miscompares = 0;

    uart_transmitter #(.CLK_HZ(16), .BAUD(1)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .tx_start (tx_start),
        .tx_byte  (tx_byte),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .UART_TX  (UART_TX)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Line level k clocks after the start-bit edge, built from the frame format.
    function automatic logic exp_line(input logic [7:0] b, input int k);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        return bits[k / CPB];
    endfunction

    task automatic check_frame(input logic [7:0] b, input int poke_k,
                               input logic [7:0] poke_byte, input int abort_k);
        logic old_start;
        old_start = tx_start;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge CLK);
            if (k == abort_k) begin
                RST_N = 1'b0;
                #1;
                check("abort_tx",   UART_TX, 1'b1);
                check("abort_busy", tx_busy, 1'b0);
                check("abort_done", tx_done, 1'b0);
                return;
            end
            check("frame_tx",   UART_TX, exp_line(b, k));
            check("frame_busy", tx_busy, 1'b1);
            check("frame_done", tx_done, 1'b0);
            if (k == poke_k) begin
                tx_start = 1'b1;
                tx_byte  = poke_byte;
            end
            if (k == poke_k + 1) tx_start = old_start;
        end
    endtask

    task automatic check_done();
        @(negedge CLK);
        check("done_pulse", tx_done, 1'b1);
        check("done_busy",  tx_busy, 1'b0);
        check("done_tx",    UART_TX, 1'b1);
    endtask

    task automatic check_idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            check("idle_tx",   UART_TX, 1'b1);
            check("idle_busy", tx_busy, 1'b0);
            check("idle_done", tx_done, 1'b0);
        end
    endtask

    task automatic send(input logic [7:0] b, input int poke_k, input logic [7:0] poke_byte);
        @(posedge CLK);
        #1;
        tx_start = 1'b1;
        tx_byte  = b;
        @(posedge CLK);
        #1;
        tx_start = 1'b0;
        check_frame(b, poke_k, poke_byte, -1);
        check_done();
        check_idle(1);
    endtask

    initial begin
        logic [7:0] rb;

        // Reset values while held, then a quiet line after release.
        repeat (3) @(negedge CLK);
        check("rst_tx",   UART_TX, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        RST_N = 1'b1;
        check_idle(5);

        send(8'hA5, -1, 8'h00);
        send(8'h01, -1, 8'h00);

        // Request with 0xFF while 0x3C is in flight must be dropped.
        send(8'h3C, 40, 8'hFF);
        check_idle(FRAME);

        // tx_start held high: 0x00 then 0xFF with a single idle cycle between.
        @(posedge CLK);
        #1;
        tx_start = 1'b1;
        tx_byte  = 8'h00;
        @(posedge CLK);
        #1;
        check_frame(8'h00, 20, 8'hFF, -1);
        check_done();
        @(posedge CLK);
        #1;
        tx_start = 1'b0;
        check_frame(8'hFF, -1, 8'h00, -1);
        check_done();
        check_idle(3);

        // Reset asserted during data bit 3 of 0x00, then 0x55 sent cleanly.
        @(posedge CLK);
        #1;
        tx_start = 1'b1;
        tx_byte  = 8'h00;
        @(posedge CLK);
        #1;
        tx_start = 1'b0;
        check_frame(8'h00, -1, 8'h00, 4 * CPB + 5);
        @(negedge CLK);
        check("held_rst_tx",   UART_TX, 1'b1);
        check("held_rst_busy", tx_busy, 1'b0);
        RST_N = 1'b1;
        check_idle(3);
        send(8'h55, -1, 8'h00);

        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge CLK);
            send(rb, -1, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
